// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drive_pkg
// Description : Shared encodings for the manual-driving state machine and
//               its downstream status/odometer block.
// Revision    : 1.0 - initial release
// ============================================================================
package drive_pkg;

  // One-hot drive state encodings
  localparam logic [3:0] ST_UNSTART  = 4'b0001;
  localparam logic [3:0] ST_START    = 4'b0010;
  localparam logic [3:0] ST_MOVING   = 4'b0100;
  localparam logic [3:0] ST_POWEROFF = 4'b1000;

  // Bit positions inside the 4-bit motion vector
  localparam int unsigned ANS_FWD   = 0;
  localparam int unsigned ANS_REV   = 1;
  localparam int unsigned ANS_LEFT  = 2;
  localparam int unsigned ANS_RIGHT = 3;

endpackage : drive_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One decimal digit of a ripple BCD counter. Carries out
//               combinationally when incremented from 9.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry_out
);

  // Carry into the next digit happens on the same edge this digit wraps
  assign carry_out = inc && (digit == 4'd9);

  // Digit register: clear has priority over increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule : bcd_digit
`default_nettype wire

// File: rtl/drive_status_odometer.sv
`default_nettype none
// ============================================================================
// Module      : drive_status_odometer
// Description : Turns the drive state and motion vector into a BCD odometer,
//               blinking turn lamps and a reversing lamp.
// Revision    : 1.0 - initial release
// ============================================================================
module drive_status_odometer
  import drive_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned BLINK_DIV = 50_000_000,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            state,
  input  logic [3:0]            answer,
  output logic [4*DIGITS-1:0]   mileage_bcd,
  output logic                  mileage_tick,
  output logic                  overflow,
  output logic                  lamp_left,
  output logic                  lamp_right,
  output logic                  lamp_rear
);

  localparam int unsigned PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

  logic [PW-1:0]   pcnt;
  logic [BW-1:0]   bcnt;
  logic            phase;
  logic            moving;
  logic            power_off;
  logic            tick_now;
  logic            blink_idle;
  logic [DIGITS:0] carry;

  // Non-one-hot states match neither compare, so they neither move nor clear
  assign moving     = (state == ST_MOVING) && (answer[ANS_FWD] || answer[ANS_REV]);
  assign power_off  = (state == ST_POWEROFF);
  assign tick_now   = moving && (pcnt == PCNT_MAX) && !power_off;
  assign blink_idle = power_off || (answer[ANS_RIGHT:ANS_LEFT] == 2'b00);

  // Prescaler: holds across stops so partial distance is not lost
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (power_off) begin
      pcnt <= '0;
    end else if (moving) begin
      pcnt <= (pcnt == PCNT_MAX) ? '0 : pcnt + PW'(1);
    end
  end

  // Tick pulse marks the edge on which the mileage advanced
  always_ff @(posedge clk) begin
    if (!rst) begin
      mileage_tick <= 1'b0;
    end else begin
      mileage_tick <= tick_now;
    end
  end

  // BCD ripple chain; the carry out of the top digit means all-9s wrapped
  assign carry[0] = tick_now;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
        .clk       (clk),
        .rst       (rst),
        .inc       (carry[i]),
        .clr       (power_off),
        .digit     (mileage_bcd[4*i +: 4]),
        .carry_out (carry[i+1])
      );
    end
  endgenerate

  // Sticky overflow, cleared only by reset or power-off
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (power_off) begin
      overflow <= 1'b0;
    end else if (carry[DIGITS]) begin
      overflow <= 1'b1;
    end
  end

  // Blink generator: phase starts high so a new turn request lights at once
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (blink_idle) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BCNT_MAX) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + BW'(1);
    end
  end

  // Lamp registers; power-off forces everything dark
  always_ff @(posedge clk) begin
    if (!rst) begin
      lamp_left  <= 1'b0;
      lamp_right <= 1'b0;
      lamp_rear  <= 1'b0;
    end else if (power_off) begin
      lamp_left  <= 1'b0;
      lamp_right <= 1'b0;
      lamp_rear  <= 1'b0;
    end else begin
      lamp_left  <= answer[ANS_LEFT]  & phase;
      lamp_right <= answer[ANS_RIGHT] & phase;
      lamp_rear  <= answer[ANS_REV];
    end
  end

endmodule : drive_status_odometer
`default_nettype wire

// File: tb/tb_drive_status_odometer.sv
`default_nettype none
// ============================================================================
// Module      : tb_drive_status_odometer
// Description : Directed self-checking bench for drive_status_odometer with
//               TICK_DIV=4, BLINK_DIV=3, DIGITS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drive_status_odometer;
  import drive_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state;
  logic [3:0] answer;
  logic [7:0] mileage_bcd;
  logic       mileage_tick;
  logic       overflow;
  logic       lamp_left;
  logic       lamp_right;
  logic       lamp_rear;

  int compared   = 0;
  int mismatched = 0;

  drive_status_odometer #(
    .TICK_DIV  (4),
    .BLINK_DIV (3),
    .DIGITS    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .answer       (answer),
    .mileage_bcd  (mileage_bcd),
    .mileage_tick (mileage_tick),
    .overflow     (overflow),
    .lamp_left    (lamp_left),
    .lamp_right   (lamp_right),
    .lamp_rear    (lamp_rear)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
  endtask

  initial begin
    int ticks;
    logic [6:0] left_pat;

    // 1. Reset with arbitrary inputs
    rst    = 1'b0;
    state  = ST_MOVING;
    answer = 4'b1111;
    cycles(2);
    chk("rst_mileage", {24'd0, mileage_bcd}, 32'h00);
    chk("rst_tick",    {31'd0, mileage_tick}, 32'd0);
    chk("rst_ovf",     {31'd0, overflow},     32'd0);
    chk("rst_lamps",   {29'd0, lamp_left, lamp_right, lamp_rear}, 32'd0);

    // 2. Moving forward 40 cycles: tick after every 4th edge
    rst    = 1'b1;
    state  = ST_MOVING;
    answer = 4'b0001;
    ticks  = 0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (mileage_tick) ticks++;
      chk($sformatf("fwd_tick_%0d", i), {31'd0, mileage_tick}, {31'd0, ((i % 4) == 3)});
    end
    chk("fwd_mileage", {24'd0, mileage_bcd}, 32'h10);
    chk("fwd_ticks",   ticks, 32'd10);

    // 3. Stop and resume keeps partial distance
    do_reset();
    state  = ST_MOVING;
    answer = 4'b0001;
    cycles(6);
    chk("sr_first", {24'd0, mileage_bcd}, 32'h01);
    state = ST_START;
    cycles(5);
    chk("sr_hold", {24'd0, mileage_bcd}, 32'h01);
    state = ST_MOVING;
    cycles(1);
    chk("sr_res1_tick", {31'd0, mileage_tick}, 32'd0);
    cycles(1);
    chk("sr_res2_tick", {31'd0, mileage_tick}, 32'd1);
    chk("sr_mileage",   {24'd0, mileage_bcd}, 32'h02);

    // 4. Wrap past 99, then power-off clear
    do_reset();
    state  = ST_MOVING;
    answer = 4'b0001;
    cycles(396);
    chk("wrap_pre",     {24'd0, mileage_bcd}, 32'h99);
    chk("wrap_pre_ovf", {31'd0, overflow},    32'd0);
    cycles(4);
    chk("wrap_mileage", {24'd0, mileage_bcd}, 32'h00);
    chk("wrap_ovf",     {31'd0, overflow},    32'd1);
    chk("wrap_tick",    {31'd0, mileage_tick}, 32'd1);
    state = ST_POWEROFF;
    cycles(1);
    chk("poff_ovf",     {31'd0, overflow},    32'd0);
    chk("poff_mileage", {24'd0, mileage_bcd}, 32'h00);
    chk("poff_tick",    {31'd0, mileage_tick}, 32'd0);

    // 5. Left blink from idle: 1,1,1,0,0,0,1
    do_reset();
    state    = ST_MOVING;
    answer   = 4'b0101;
    left_pat = 7'b1000111;
    for (int i = 0; i < 7; i++) begin
      cycles(1);
      chk($sformatf("blink_left_%0d", i),  {31'd0, lamp_left},  {31'd0, left_pat[i]});
      chk($sformatf("blink_right_%0d", i), {31'd0, lamp_right}, 32'd0);
      chk($sformatf("blink_rear_%0d", i),  {31'd0, lamp_rear},  32'd0);
    end

    // 6. Power-off on the same cycle pcnt reaches 3 while reversing right
    do_reset();
    state  = ST_MOVING;
    answer = 4'b1010;
    cycles(3);
    chk("sim_pre_mileage", {24'd0, mileage_bcd}, 32'h00);
    chk("sim_pre_right",   {31'd0, lamp_right},  32'd1);
    chk("sim_pre_rear",    {31'd0, lamp_rear},   32'd1);
    state = ST_POWEROFF;
    cycles(1);
    chk("sim_tick",    {31'd0, mileage_tick}, 32'd0);
    chk("sim_mileage", {24'd0, mileage_bcd},  32'h00);
    chk("sim_lamps",   {29'd0, lamp_left, lamp_right, lamp_rear}, 32'd0);
    chk("sim_ovf",     {31'd0, overflow},     32'd0);
    // Prescaler was cleared, so one moving cycle must not tick
    state = ST_MOVING;
    cycles(1);
    chk("sim_after_tick", {31'd0, mileage_tick}, 32'd0);
    chk("sim_after_rear", {31'd0, lamp_rear},    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_drive_status_odometer
`default_nettype wire
